// File: rtl/fetch_unit_bp_pkg.sv
// Shared types and helpers for the branch-predicting fetch stage.
// BTB entry fields are sized for the widest supported configuration.
package fetch_unit_bp_pkg;

    localparam int unsigned MAX_XLEN     = 64;
    localparam int unsigned MAX_CTR_BITS = 4;

    localparam logic [MAX_XLEN-1:0] RESET_PC_DEFAULT = '0;

    typedef logic [MAX_XLEN-1:0]     btb_word_t;
    typedef logic [MAX_CTR_BITS-1:0] btb_ctr_t;

    typedef struct packed {
        logic      valid;
        btb_word_t tag;
        btb_word_t target;
        btb_ctr_t  ctr;
    } btb_entry_t;

    function automatic int unsigned idx_width(int unsigned entries);
        return $clog2(entries);
    endfunction

    function automatic int unsigned tag_width(int unsigned xlen,
                                              int unsigned entries);
        return xlen - idx_width(entries) - 2;
    endfunction

    function automatic btb_ctr_t ctr_weak_taken(int unsigned bits);
        return btb_ctr_t'(1) << (bits - 1);
    endfunction

    function automatic btb_ctr_t ctr_weak_not_taken(int unsigned bits);
        return ctr_weak_taken(bits) - btb_ctr_t'(1);
    endfunction

endpackage

// File: rtl/fetch_unit_bp_btb_table.sv
// Direct-mapped BTB: combinational lookup, one synchronous update port.
// Lookup sees pre-update contents when both touch the same entry.
module btb_table
    import fetch_unit_bp_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lk_pc_i,
    output logic            lk_taken_o,
    output logic [XLEN-1:0] lk_target_o,
    input  logic            up_valid_i,
    input  logic [XLEN-1:0] up_pc_i,
    input  logic            up_taken_i,
    input  logic [XLEN-1:0] up_target_i
);

    localparam int unsigned IDX_W = idx_width(ENTRIES);
    localparam int unsigned TAG_W = tag_width(XLEN, ENTRIES);

    localparam btb_ctr_t CTR_WT  = ctr_weak_taken(CTR_BITS);
    localparam btb_ctr_t CTR_WNT = ctr_weak_not_taken(CTR_BITS);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    localparam btb_entry_t RESET_ENTRY = '{
        valid:  1'b0,
        tag:    '0,
        target: '0,
        ctr:    CTR_WNT
    };

    btb_entry_t mem_q [ENTRIES];

    logic [IDX_W-1:0]    lk_idx;
    logic [IDX_W-1:0]    up_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic [TAG_W-1:0]    up_tag;
    btb_entry_t          lk_e;
    btb_entry_t          up_e;
    btb_entry_t          wr_e;
    logic                lk_hit;
    logic                up_hit;
    logic                wr_en;
    logic [CTR_BITS-1:0] ctr;
    logic                unused_bits;

    assign lk_idx = lk_pc_i[IDX_W+1:2];
    assign lk_tag = lk_pc_i[XLEN-1:IDX_W+2];
    assign up_idx = up_pc_i[IDX_W+1:2];
    assign up_tag = up_pc_i[XLEN-1:IDX_W+2];

    assign lk_e        = mem_q[lk_idx];
    assign lk_hit      = lk_e.valid && (lk_e.tag == btb_word_t'(lk_tag));
    assign lk_taken_o  = lk_hit && lk_e.ctr[CTR_BITS-1];
    assign lk_target_o = lk_e.target[XLEN-1:0];

    // Byte-offset bits and padding above the configured widths carry no state.
    assign unused_bits = ^{lk_pc_i[1:0], up_pc_i[1:0], lk_e.target, lk_e.ctr};

    always_comb begin
        up_e   = mem_q[up_idx];
        up_hit = up_e.valid && (up_e.tag == btb_word_t'(up_tag));
        ctr    = up_e.ctr[CTR_BITS-1:0];
        wr_en  = 1'b0;
        wr_e   = up_e;
        if (up_valid_i) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (up_taken_i) begin
                    if (ctr != CTR_MAX) begin
                        ctr = ctr + CTR_BITS'(1);
                    end
                    wr_e.target = btb_word_t'(up_target_i);
                end else if (ctr != '0) begin
                    ctr = ctr - CTR_BITS'(1);
                end
                wr_e.ctr = btb_ctr_t'(ctr);
            end else if (up_taken_i) begin
                wr_en       = 1'b1;
                wr_e.valid  = 1'b1;
                wr_e.tag    = btb_word_t'(up_tag);
                wr_e.target = btb_word_t'(up_target_i);
                wr_e.ctr    = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: RESET_ENTRY};
        end else if (wr_en) begin
            mem_q[up_idx] <= wr_e;
        end
    end

endmodule

// File: rtl/fetch_unit_bp.sv
// Fetch stage: PC register, predicted next-PC selection, IF/ID register.
// A correctly predicted taken branch redirects fetch with no bubble.
module fetch_unit_bp
    import fetch_unit_bp_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter int unsigned     CTR_BITS    = 2,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc4,
    output logic            id_pred_taken,
    output logic [XLEN-1:0] id_pred_target
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc4;
    logic            bp_taken;
    logic [XLEN-1:0] bp_target;
    logic [XLEN-1:0] seq_or_bp;

    logic            id_valid_q;
    logic            id_valid_d;
    logic [XLEN-1:0] id_instr_q;
    logic [XLEN-1:0] id_instr_d;
    logic [XLEN-1:0] id_pc4_q;
    logic [XLEN-1:0] id_pc4_d;
    logic            id_pt_q;
    logic            id_pt_d;
    logic [XLEN-1:0] id_ptgt_q;
    logic [XLEN-1:0] id_ptgt_d;

    btb_table #(
        .XLEN     (XLEN),
        .ENTRIES  (BTB_ENTRIES),
        .CTR_BITS (CTR_BITS)
    ) u_btb (
        .clk         (clk),
        .reset       (reset),
        .lk_pc_i     (pc_q),
        .lk_taken_o  (bp_taken),
        .lk_target_o (bp_target),
        .up_valid_i  (upd_valid),
        .up_pc_i     (upd_pc),
        .up_taken_i  (upd_taken),
        .up_target_i (upd_target)
    );

    assign pc4       = pc_q + XLEN'(4);
    assign seq_or_bp = bp_taken ? bp_target : pc4;

    always_comb begin
        pc_d = seq_or_bp;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_comb begin
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc4_d   = id_pc4_q;
        id_pt_d    = id_pt_q;
        id_ptgt_d  = id_ptgt_q;
        if (redirect_valid) begin
            id_valid_d = 1'b0;
            id_instr_d = '0;
            id_pc4_d   = '0;
            id_pt_d    = 1'b0;
            id_ptgt_d  = '0;
        end else if (!stall) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_data;
            id_pc4_d   = pc4;
            id_pt_d    = bp_taken;
            id_ptgt_d  = seq_or_bp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            id_pc4_q   <= '0;
            id_pt_q    <= 1'b0;
            id_ptgt_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc4_q   <= id_pc4_d;
            id_pt_q    <= id_pt_d;
            id_ptgt_q  <= id_ptgt_d;
        end
    end

    assign imem_addr      = pc_q;
    assign id_valid       = id_valid_q;
    assign id_instr       = id_instr_q;
    assign id_pc4         = id_pc4_q;
    assign id_pred_taken  = id_pt_q;
    assign id_pred_target = id_ptgt_q;

endmodule

// File: tb/tb_fetch_unit_bp.sv
// Directed bench for fetch_unit_bp with a per-cycle reference model.
// Inputs change 2 time units after each rising edge; outputs are checked mid-cycle.
module tb_fetch_unit_bp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(logic [31:0] a);
        return ~a ^ 32'h0013_5A13;
    endfunction

    assign imem_data = instr_of(imem_addr);

    fetch_unit_bp #(
        .XLEN        (32),
        .BTB_ENTRIES (16),
        .CTR_BITS    (2),
        .RESET_PC    (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc4         (id_pc4),
        .id_pred_taken  (id_pred_taken),
        .id_pred_target (id_pred_target)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: BTB as plain arrays, counters as integers 0..3.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_pt;
    logic [31:0] m_tgt;
    bit          b_valid [16];
    logic [31:0] b_tag [16];
    logic [31:0] b_target [16];
    int          b_ctr [16];

    always @(posedge clk) begin : model
        int li;
        int ui;
        bit pt;
        logic [31:0] seq;
        if (reset) begin
            m_pc = 32'h0;
            m_valid = 1'b0;
            m_instr = '0;
            m_pc4 = '0;
            m_pt = 1'b0;
            m_tgt = '0;
            for (int i = 0; i < 16; i++) begin
                b_valid[i] = 1'b0;
                b_ctr[i] = 1;
            end
        end else begin
            li = int'((m_pc >> 2) % 16);
            pt = b_valid[li] && (b_tag[li] == (m_pc >> 6)) && (b_ctr[li] >= 2);
            seq = m_pc + 32'd4;
            if (redirect_valid) begin
                m_valid = 1'b0;
                m_instr = '0;
                m_pc4 = '0;
                m_pt = 1'b0;
                m_tgt = '0;
            end else if (!stall) begin
                m_valid = 1'b1;
                m_instr = instr_of(m_pc);
                m_pc4 = seq;
                m_pt = pt;
                m_tgt = pt ? b_target[li] : seq;
            end
            if (redirect_valid) m_pc = redirect_pc;
            else if (!stall) m_pc = pt ? b_target[li] : seq;
            if (upd_valid) begin
                ui = int'((upd_pc >> 2) % 16);
                if (b_valid[ui] && (b_tag[ui] == (upd_pc >> 6))) begin
                    if (upd_taken) begin
                        b_ctr[ui] = (b_ctr[ui] < 3) ? b_ctr[ui] + 1 : 3;
                        b_target[ui] = upd_target;
                    end else begin
                        b_ctr[ui] = (b_ctr[ui] > 0) ? b_ctr[ui] - 1 : 0;
                    end
                end else if (upd_taken) begin
                    b_valid[ui] = 1'b1;
                    b_tag[ui] = upd_pc >> 6;
                    b_target[ui] = upd_target;
                    b_ctr[ui] = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_imem_addr", imem_addr, m_pc);
            check("m_id_valid", 32'(id_valid), 32'(m_valid));
            check("m_id_instr", id_instr, m_instr);
            check("m_id_pc4", id_pc4, m_pc4);
            check("m_id_pred_taken", 32'(id_pred_taken), 32'(m_pt));
            check("m_id_pred_target", id_pred_target, m_tgt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic redirect_to(logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic train(logic [31:0] pc, bit tk, logic [31:0] tgt);
        upd_valid = 1'b1;
        upd_pc = pc;
        upd_taken = tk;
        upd_target = tgt;
        tick();
        upd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_addr", imem_addr, 32'h0);
        check("reset_valid", 32'(id_valid), 32'h0);
        check("reset_pc4", id_pc4, 32'h0);
        reset = 1'b0;

        tick();
        check("seq_addr1", imem_addr, 32'h4);
        check("seq_valid1", 32'(id_valid), 32'h1);
        check("seq_pc4_1", id_pc4, 32'h4);
        repeat (3) tick();
        check("seq_addr4", imem_addr, 32'h10);
        check("seq_pc4_4", id_pc4, 32'h10);
        check("seq_pt", 32'(id_pred_taken), 32'h0);

        train(32'h20, 1'b1, 32'h100);
        repeat (3) tick();
        check("reach_20", imem_addr, 32'h20);
        tick();
        check("bp_addr", imem_addr, 32'h100);
        check("bp_pt", 32'(id_pred_taken), 32'h1);
        check("bp_tgt", id_pred_target, 32'h100);
        check("bp_pc4", id_pc4, 32'h24);

        train(32'h20, 1'b0, 32'h0);
        train(32'h20, 1'b0, 32'h0);
        redirect_to(32'h20);
        check("redir_addr", imem_addr, 32'h20);
        check("redir_flush", 32'(id_valid), 32'h0);
        tick();
        check("nt_fallthru", imem_addr, 32'h24);
        check("nt_pt", 32'(id_pred_taken), 32'h0);

        train(32'h20, 1'b1, 32'h100);
        train(32'h20, 1'b1, 32'h100);
        redirect_to(32'h20);
        tick();
        check("retrained", imem_addr, 32'h100);

        stall = 1'b1;
        redirect_to(32'h400);
        stall = 1'b0;
        check("stall_redir_addr", imem_addr, 32'h400);
        check("stall_redir_valid", 32'(id_valid), 32'h0);
        tick();
        stall = 1'b1;
        repeat (3) tick();
        check("stall_hold_addr", imem_addr, 32'h404);
        check("stall_hold_pc4", id_pc4, 32'h404);
        check("stall_hold_instr", id_instr, instr_of(32'h400));
        stall = 1'b0;

        train(32'h60, 1'b1, 32'h200);
        redirect_to(32'h20);
        tick();
        check("alias_evict", imem_addr, 32'h24);
        redirect_to(32'h60);
        tick();
        check("alias_new", imem_addr, 32'h200);

        redirect_to(32'h80);
        train(32'h80, 1'b1, 32'h500);
        check("same_cycle_old", imem_addr, 32'h84);
        redirect_to(32'h80);
        tick();
        check("same_cycle_new", imem_addr, 32'h500);

        redirect_to(32'hFFFF_FFFC);
        tick();
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4", id_pc4, 32'h0);

        reset = 1'b1;
        upd_valid = 1'b1;
        upd_pc = 32'h20;
        upd_taken = 1'b1;
        upd_target = 32'h300;
        tick();
        reset = 1'b0;
        upd_valid = 1'b0;
        check("midreset_addr", imem_addr, 32'h0);
        check("midreset_valid", 32'(id_valid), 32'h0);
        tick();
        redirect_to(32'h60);
        tick();
        check("post_reset_60", imem_addr, 32'h64);
        redirect_to(32'h20);
        tick();
        check("post_reset_20", imem_addr, 32'h24);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
